// File: rtl/demux1to4_buf.sv
// Registered 1:4 demultiplexer: routes w into one of four per-channel FIFOs with valid/ready handshakes.
// Optional build macro DEMUX_ROUND_ROBIN_EN replaces s with an internal round-robin channel pointer.
module demux1to4_buf #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] w,
  input  logic [1:0]       s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] f0,
  output logic [WIDTH-1:0] f1,
  output logic [WIDTH-1:0] f2,
  output logic [WIDTH-1:0] f3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  input  logic             r0,
  input  logic             r1,
  input  logic             r2,
  input  logic             r3
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Handshake: input moves when in_valid && in_ready at a rising edge; channel n
  // pops when vn && rn at a rising edge. in_ready never looks at r0..r3.
  logic [1:0]            sel;
  logic                  accept;
  logic [3:0]            r_vec;
  logic [3:0]            push;
  logic [3:0]            pop;
  logic [3:0]            full_vec;
  logic [3:0]            empty_vec;
  logic [3:0][WIDTH-1:0] head;

  assign r_vec = {r3, r2, r1, r0};

`ifdef DEMUX_ROUND_ROBIN_EN
  logic [1:0] rr;
  logic       unused_s;

  assign unused_s = ^s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= 2'd0;
    end else if (accept) begin
      rr <= rr + 2'd1;
    end
  end

  assign sel = rr;
`else
  assign sel = s;
`endif

  assign in_ready = !full_vec[sel];
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    assign full_vec[i]  = (count == FULL_CNT);
    assign empty_vec[i] = (count == '0);
    assign push[i]      = accept && (sel == 2'(i));
    assign pop[i]       = r_vec[i] && !empty_vec[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[i])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    // Storage needs no reset: the head is masked to 0 whenever the channel is empty.
    always_ff @(posedge clk) begin
      if (push[i]) mem[wr_ptr] <= w;
    end

    assign head[i] = empty_vec[i] ? '0 : mem[rd_ptr];
  end

  assign f0 = head[0];
  assign f1 = head[1];
  assign f2 = head[2];
  assign f3 = head[3];
  assign v0 = !empty_vec[0];
  assign v1 = !empty_vec[1];
  assign v2 = !empty_vec[2];
  assign v3 = !empty_vec[3];

endmodule

// File: tb/tb_demux1to4_buf.sv
// Directed self-checking bench for demux1to4_buf (WIDTH=3, DEPTH=2).
// Built with DEMUX_ROUND_ROBIN_EN it runs the reset and round-robin vectors instead of the s-routed ones.
module tb_demux1to4_buf;

  logic       clk;
  logic       rst_n;
  logic [2:0] w;
  logic [1:0] s;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] f0, f1, f2, f3;
  logic       v0, v1, v2, v3;
  logic       r0, r1, r2, r3;

  int n_cmp;
  int n_err;

  demux1to4_buf #(.WIDTH(3), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .w(w), .s(s), .in_valid(in_valid), .in_ready(in_ready),
    .f0(f0), .f1(f1), .f2(f2), .f3(f3),
    .v0(v0), .v1(v1), .v2(v2), .v3(v3),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_ch(input string tag, input int n, input logic exp_v, input logic [2:0] exp_f);
    logic       act_v;
    logic [2:0] act_f;
    case (n)
      0:       begin act_v = v0; act_f = f0; end
      1:       begin act_v = v1; act_f = f1; end
      2:       begin act_v = v2; act_f = f2; end
      default: begin act_v = v3; act_f = f3; end
    endcase
    check($sformatf("%s_v%0d", tag, n), 32'(act_v), 32'(exp_v));
    check($sformatf("%s_f%0d", tag, n), 32'(act_f), 32'(exp_f));
  endtask

  task automatic check_all_empty(input string tag);
    for (int n = 0; n < 4; n++) check_ch(tag, n, 1'b0, 3'd0);
  endtask

  // driver: advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] ch, input logic [2:0] data);
    s = ch; w = data; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; w = '0; s = '0; in_valid = 1'b0;
    r0 = 1'b0; r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;

    // reset state
    #12;
    check_all_empty("rst");
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    repeat (3) step();
    check_all_empty("idle");
    check("idle_in_ready", 32'(in_ready), 32'd1);

`ifdef DEMUX_ROUND_ROBIN_EN
    // round-robin: s held at 3 is ignored, consumers always ready
    r0 = 1'b1; r1 = 1'b1; r2 = 1'b1; r3 = 1'b1;
    s = 2'd3; in_valid = 1'b1;
    w = 3'd1; step(); check_ch("rr1", 0, 1'b1, 3'd1); check_ch("rr1", 3, 1'b0, 3'd0);
    w = 3'd2; step(); check_ch("rr2", 1, 1'b1, 3'd2); check_ch("rr2", 0, 1'b0, 3'd0);
    w = 3'd3; step(); check_ch("rr3", 2, 1'b1, 3'd3); check_ch("rr3", 1, 1'b0, 3'd0);
    w = 3'd4; step(); check_ch("rr4", 3, 1'b1, 3'd4); check_ch("rr4", 2, 1'b0, 3'd0);
    in_valid = 1'b0;
    step();
    check_all_empty("rr_drain");
    // pointer wrapped back to channel 0
    w = 3'd5; in_valid = 1'b1; step(); in_valid = 1'b0;
    check_ch("rr_wrap", 0, 1'b1, 3'd5);
    check_ch("rr_wrap", 3, 1'b0, 3'd0);
    // stall: ch1 full while consumers idle, rr waits on it
    r0 = 1'b0; r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;
    step();
    w = 3'd6; in_valid = 1'b1; step();   // ch1 <- 6
    check_ch("rr_stall_a", 1, 1'b1, 3'd6);
`else
    // single push to ch1
    push(2'd1, 3'b010);
    check_ch("t2", 1, 1'b1, 3'b010);
    check_ch("t2", 0, 1'b0, 3'd0);
    check_ch("t2", 2, 1'b0, 3'd0);
    check_ch("t2", 3, 1'b0, 3'd0);

    // fill ch2, in_ready follows s
    push(2'd2, 3'b011);
    push(2'd2, 3'b100);
    s = 2'd2; #1;
    check("t3_ready_full", 32'(in_ready), 32'd0);
    check_ch("t3", 2, 1'b1, 3'b011);
    s = 2'd0; #1;
    check("t3_ready_other", 32'(in_ready), 32'd1);
    push(2'd0, 3'b111);
    check_ch("t3", 0, 1'b1, 3'b111);

    // refused push into a full channel, even while it pops this cycle
    s = 2'd2; w = 3'b101; in_valid = 1'b1; r2 = 1'b1; #1;
    check("t3_ready_pop", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    check_ch("t3_refuse", 2, 1'b1, 3'b100);
    step();
    r2 = 1'b0;
    check_ch("t3_drain", 2, 1'b0, 3'd0);

    // simultaneous push and pop on a one-entry channel
    push(2'd2, 3'b011);
    check_ch("t4_pre", 2, 1'b1, 3'b011);
    s = 2'd2; w = 3'b100; in_valid = 1'b1; r2 = 1'b1;
    step();
    in_valid = 1'b0;
    check_ch("t4_pp", 2, 1'b1, 3'b100);
    step();
    r2 = 1'b0;
    check_ch("t4_pop", 2, 1'b0, 3'd0);

    // pop on empty channel ignored, then FIFO order on ch3
    r3 = 1'b1; step(); r3 = 1'b0;
    check_ch("under", 3, 1'b0, 3'd0);
    push(2'd3, 3'b001);
    push(2'd3, 3'b110);
    check_ch("ord", 3, 1'b1, 3'b001);
    r3 = 1'b1; step(); r3 = 1'b0;
    check_ch("ord2", 3, 1'b1, 3'b110);

    // independence: ch0 pops while ch1 is being filled
    r0 = 1'b1; push(2'd1, 3'b101); r0 = 1'b0;
    check_ch("indep", 0, 1'b0, 3'd0);
    check_ch("indep", 1, 1'b1, 3'b010);
    push(2'd3, 3'b111);
    s = 2'd1; #1;
    check("t5_ready_pre", 32'(in_ready), 32'd0);
    check_ch("t5_pre", 3, 1'b1, 3'b110);

    // mid-cycle reset with ch1 and ch3 full
    #2 rst_n = 1'b0;
    #1;
    check_all_empty("t5_async");
    check("t5_ready", 32'(in_ready), 32'd1);
    #2 rst_n = 1'b1;
    step();
    check_all_empty("t5_after");
    push(2'd1, 3'b011);
    check_ch("t5_restart", 1, 1'b1, 3'b011);
    push(2'd1, 3'b100);
    s = 2'd1; #1;
    check("t5_refill_full", 32'(in_ready), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
